// File: rtl/lector_contadores.sv
// lector_contadores
// Requester side of the output-counter read interface. A start pulse
// launches a sweep over the counters selected by mascara. For each selected
// index the block raises req with idx until the FSM reports idle. It then
// waits for the valid response, stores data in the matching cuenta_N and
// adds it to total. A stall longer than TIMEOUT cycles in either phase
// aborts the sweep and raises the sticky error flag.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   start, mascara  : sweep launch pulse and channel selection mask
//   idle            : a request is accepted when req && idle at a posedge
//   valid, data     : counter response, one cycle after an accepted request
//   req, idx        : read request and index of the requested counter
//   cuenta_0..3     : captured counter values
//   total           : sum of the values captured in the current sweep
//   busy, done      : sweep in progress / one-cycle end-of-sweep pulse
//   error           : sticky timeout flag, cleared by the next accepted start
module lector_contadores #(
  parameter int DATA_W  = 5,
  parameter int TIMEOUT = 8,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        mascara,
  input  logic              idle,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              req,
  output logic [1:0]        idx,
  output logic [DATA_W-1:0] cuenta_0,
  output logic [DATA_W-1:0] cuenta_1,
  output logic [DATA_W-1:0] cuenta_2,
  output logic [DATA_W-1:0] cuenta_3,
  output logic [DATA_W+1:0] total,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    ST_ESPERA = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FIN    = 2'd3
  } state_t;

  // The counter holds the number of stalled cycles already spent; reaching
  // TIMEOUT-1 on a further stalled edge means TIMEOUT cycles have elapsed.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  state_t            state_r, state_s;
  logic [3:0]        mask_r, mask_s;
  logic [TO_W-1:0]   to_cnt_r, to_cnt_s;
  logic [DATA_W-1:0] cuenta_r [4];
  logic [DATA_W-1:0] cuenta_s [4];
  logic              req_s;
  logic [1:0]        idx_s;
  logic [DATA_W+1:0] total_s;
  logic              busy_s;
  logic              done_s;
  logic              error_s;
  logic [3:0]        rest_s;

  // Index of the lowest set bit; only meaningful for a non-zero mask.
  function automatic logic [1:0] lowest_bit(input logic [3:0] m);
    logic [1:0] r;
    if (m[0]) begin
      r = 2'd0;
    end else if (m[1]) begin
      r = 2'd1;
    end else if (m[2]) begin
      r = 2'd2;
    end else begin
      r = 2'd3;
    end
    return r;
  endfunction

  assign cuenta_0 = cuenta_r[0];
  assign cuenta_1 = cuenta_r[1];
  assign cuenta_2 = cuenta_r[2];
  assign cuenta_3 = cuenta_r[3];

  // Next-state and next-output computation for the sweep FSM.
  always_comb begin
    state_s  = state_r;
    mask_s   = mask_r;
    to_cnt_s = to_cnt_r;
    cuenta_s = cuenta_r;
    req_s    = req;
    idx_s    = idx;
    total_s  = total;
    busy_s   = busy;
    done_s   = 1'b0;
    error_s  = error;
    // Channels still pending once the current one has been served. Bits are
    // cleared in ascending order, so the lowest remaining bit is the next
    // one above idx.
    rest_s   = mask_r & ~(4'b0001 << idx);

    case (state_r)
      ST_ESPERA: begin
        if (start) begin
          mask_s   = mascara;
          cuenta_s = '{default: '0};
          total_s  = '0;
          error_s  = 1'b0;
          busy_s   = 1'b1;
          to_cnt_s = '0;
          if (mascara == 4'b0000) begin
            state_s = ST_FIN;
          end else begin
            idx_s   = lowest_bit(mascara);
            req_s   = 1'b1;
            state_s = ST_REQ;
          end
        end else begin
          state_s = ST_ESPERA;
        end
      end

      ST_REQ: begin
        if (idle) begin
          // Accepted; valid seen on this same edge is deliberately ignored.
          req_s    = 1'b0;
          to_cnt_s = '0;
          state_s  = ST_WAIT;
        end else if (to_cnt_r == TO_LAST) begin
          req_s    = 1'b0;
          error_s  = 1'b1;
          to_cnt_s = '0;
          state_s  = ST_FIN;
        end else begin
          to_cnt_s = to_cnt_r + TO_ONE;
        end
      end

      ST_WAIT: begin
        if (valid) begin
          cuenta_s[idx] = data;
          total_s       = total + {2'b00, data};
          mask_s        = rest_s;
          to_cnt_s      = '0;
          if (rest_s == 4'b0000) begin
            state_s = ST_FIN;
          end else begin
            idx_s   = lowest_bit(rest_s);
            req_s   = 1'b1;
            state_s = ST_REQ;
          end
        end else if (to_cnt_r == TO_LAST) begin
          error_s  = 1'b1;
          to_cnt_s = '0;
          state_s  = ST_FIN;
        end else begin
          to_cnt_s = to_cnt_r + TO_ONE;
        end
      end

      ST_FIN: begin
        done_s  = 1'b1;
        busy_s  = 1'b0;
        state_s = ST_ESPERA;
      end

      default: begin
        req_s   = 1'b0;
        busy_s  = 1'b0;
        state_s = ST_ESPERA;
      end
    endcase
  end

  // State and registered-output update; reset aborts any sweep silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_ESPERA;
      mask_r   <= 4'b0000;
      to_cnt_r <= '0;
      cuenta_r <= '{default: '0};
      req      <= 1'b0;
      idx      <= 2'd0;
      total    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_r  <= state_s;
      mask_r   <= mask_s;
      to_cnt_r <= to_cnt_s;
      cuenta_r <= cuenta_s;
      req      <= req_s;
      idx      <= idx_s;
      total    <= total_s;
      busy     <= busy_s;
      done     <= done_s;
      error    <= error_s;
    end
  end

endmodule
